// File: rtl/cudb_frame_tx.sv
// -----------------------------------------------------------------------------
// cudb_frame_tx
// Reads one block of FRAME_LEN bytes from the CUDB RAM and sends it as a frame
// over a valid/ready byte link:
//   HDR0, HDR1, ID, payload[0..FRAME_LEN-1], CKS
// Block start address S = {base[8:0], 4'd0}; ID = base[7:0].
// CKS = 8-bit wrap-around sum of ID and all payload bytes.
//
// Ports
//   clk            clock, all state on the rising edge
//   rst_n          asynchronous active-low reset
//   i_start        one-cycle request to send a block (honoured only when idle)
//   im_base_addr   block number, sampled together with i_start
//   o_busy         frame in progress
//   o_done         one-cycle pulse after the checksum byte has been accepted
//   o_cudb_rden    RAM read strobe, one cycle per payload byte
//   om_cudb_addr   RAM read address (holds its last value between reads)
//   im_cudb_rdata  RAM read data, valid RD_LAT cycles after the strobe
//   o_tx_valid     byte available on om_tx_data
//   om_tx_data     transmit byte (0 whenever o_tx_valid is low)
//   i_tx_ready     downstream accepts the byte on this edge
// -----------------------------------------------------------------------------
module cudb_frame_tx #(
    parameter int          FRAME_LEN = 128,
    parameter int          RD_LAT    = 1,
    parameter logic [7:0]  HDR0      = 8'hEB,
    parameter logic [7:0]  HDR1      = 8'h90
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [9:0]  im_base_addr,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_cudb_rden,
    output logic [12:0] om_cudb_addr,
    input  logic [7:0]  im_cudb_rdata,
    output logic        o_tx_valid,
    output logic [7:0]  om_tx_data,
    input  logic        i_tx_ready
);

    typedef enum logic [3:0] {
        IDLE, SEND_H0, SEND_H1, SEND_ID, RD_REQ, RD_WAIT, SEND_PL, SEND_CKS, DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [12:0] start_addr_reg, start_addr_next;
    logic [7:0]  id_reg, id_next;
    logic [8:0]  cnt_reg, cnt_next;
    logic [8:0]  cnt_inc;
    logic [1:0]  wait_reg, wait_next;
    logic [7:0]  cks_reg, cks_next;
    logic [7:0]  data_reg, data_next;
    logic [12:0] addr_reg, addr_next;
    logic        valid_reg, valid_next;
    logic        rden_reg, rden_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        xfer;

    // Block numbers are 9 bits wide in the address map; bit 9 is not used.
    logic unused_base_msb;
    assign unused_base_msb = im_base_addr[9];

    assign xfer    = valid_reg & i_tx_ready;
    assign cnt_inc = cnt_reg + 9'd1;

    always_comb begin
        state_next      = state_reg;
        start_addr_next = start_addr_reg;
        id_next         = id_reg;
        cnt_next        = cnt_reg;
        wait_next       = wait_reg;
        cks_next        = cks_reg;
        data_next       = data_reg;
        addr_next       = addr_reg;

        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    state_next      = SEND_H0;
                    start_addr_next = {im_base_addr[8:0], 4'd0};
                    id_next         = im_base_addr[7:0];
                    cnt_next        = 9'd0;
                    cks_next        = 8'd0;
                    data_next       = HDR0;
                end
            end
            SEND_H0: if (xfer) begin
                state_next = SEND_H1;
                data_next  = HDR1;
            end
            SEND_H1: if (xfer) begin
                state_next = SEND_ID;
                data_next  = id_reg;
            end
            SEND_ID: if (xfer) begin
                state_next = RD_REQ;
                cnt_next   = 9'd0;
                cks_next   = id_reg;          // ID is part of the checksum
                addr_next  = start_addr_reg;  // address of payload[0]
            end
            RD_REQ: begin
                state_next = RD_WAIT;
                wait_next  = 2'd0;
            end
            RD_WAIT: begin
                // The last wait cycle is the one in which read data is valid.
                if (wait_reg == 2'(RD_LAT - 1)) begin
                    state_next = SEND_PL;
                    data_next  = im_cudb_rdata;
                    cks_next   = cks_reg + im_cudb_rdata;
                end else begin
                    wait_next = wait_reg + 2'd1;
                end
            end
            SEND_PL: if (xfer) begin
                if (cnt_reg == 9'(FRAME_LEN - 1)) begin
                    state_next = SEND_CKS;
                    data_next  = cks_reg;
                end else begin
                    state_next = RD_REQ;
                    cnt_next   = cnt_inc;
                    // 13-bit add wraps around the top of the RAM.
                    addr_next  = start_addr_reg + {4'd0, cnt_inc};
                end
            end
            SEND_CKS: if (xfer) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase

        // Outputs are registered from the decided next state.
        valid_next = state_next inside {SEND_H0, SEND_H1, SEND_ID, SEND_PL, SEND_CKS};
        rden_next  = (state_next == RD_REQ);
        busy_next  = (state_next != IDLE);
        done_next  = (state_next == DONE);
        if (!valid_next) begin
            data_next = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            start_addr_reg <= 13'd0;
            id_reg         <= 8'd0;
            cnt_reg        <= 9'd0;
            wait_reg       <= 2'd0;
            cks_reg        <= 8'd0;
            data_reg       <= 8'd0;
            addr_reg       <= 13'd0;
            valid_reg      <= 1'b0;
            rden_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            start_addr_reg <= start_addr_next;
            id_reg         <= id_next;
            cnt_reg        <= cnt_next;
            wait_reg       <= wait_next;
            cks_reg        <= cks_next;
            data_reg       <= data_next;
            addr_reg       <= addr_next;
            valid_reg      <= valid_next;
            rden_reg       <= rden_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    assign o_busy       = busy_reg;
    assign o_done       = done_reg;
    assign o_cudb_rden  = rden_reg;
    assign om_cudb_addr = addr_reg;
    assign o_tx_valid   = valid_reg;
    assign om_tx_data   = data_reg;

endmodule
